// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with bounded lock ownership and a one-cycle read return.
// m0 is the core load/store port and m1 is the debug/loader port. A granted master can ask
// to keep ownership with its lock input, for at most LOCK_MAX consecutive beats.
// Define DMEM_ARB_RR_EN for round-robin contention. Without it, m0 always wins contention.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_MAX);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;   // 1 means m1 held the most recent grant
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rv0_q, rv1_q;
  logic            gnt0, gnt1;
  logic            pick1;            // contention winner is m1
  logic            own_hit;
  logic            grant_lock;
  logic [CntW-1:0] beats;

`ifdef DMEM_ARB_RR_EN
  assign pick1 = ~last_q;
`else
  assign pick1 = 1'b0;
  logic unused_last;
  assign unused_last = last_q;
`endif

  // Grant: the lock owner keeps the port while it requests; otherwise arbitrate.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == StLock0 && m0_req) begin
        gnt0 = 1'b1;
      end else if (state_q == StLock1 && m1_req) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        gnt0 = ~pick1;
        gnt1 = pick1;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Memory-side mux of the granted master; everything is zero with no grant.
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // Next state: lock ownership and beat counting. A cycle with no grant always ends in idle.
  always_comb begin
    state_d    = StIdle;
    cnt_d      = '0;
    last_d     = last_q;
    own_hit    = gnt1 ? (state_q == StLock1) : (state_q == StLock0);
    grant_lock = gnt1 ? m1_lock : m0_lock;
    // A grant that does not continue an existing lock starts a new count from zero.
    beats      = (own_hit ? cnt_q : '0) + CntW'(1);
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      // The beat that reaches LOCK_MAX releases the lock even if lock is still requested.
      if (grant_lock && beats < CntMax) begin
        state_d = gnt1 ? StLock1 : StLock0;
        cnt_d   = beats;
      end
    end
  end

  // State registers and the one-deep read-return pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv0_q   <= gnt0 & ~m0_we;
      rv1_q   <= gnt1 & ~m1_we;
    end
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. It runs directed scenarios and then randomized traffic.
// A transaction-level reference model tracks the lock owner, the beat count, the last winner,
// the expected memory contents and any pending read return.
module tb_dmem_arbiter;

  localparam int unsigned LockMax = 16;

  logic        clk;
  logic        rst;
  logic [1:0]  req, we, lock;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .LOCK_MAX(LockMax)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (req[0]),
    .m0_we    (we[0]),
    .m0_lock  (lock[0]),
    .m0_addr  (addr[0]),
    .m0_wdata (wdata[0]),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (req[1]),
    .m1_we    (we[1]),
    .m1_lock  (lock[1]),
    .m1_addr  (addr[1]),
    .m1_wdata (wdata[1]),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 | (i * 32'h0101);
  endfunction

  // Environment memory. A read returns data one cycle after its strobe. Unwritten words read as pat().
  bit   [15:0] env_wr;
  logic [31:0] env_mem [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr[5:2]] <= mem_wdata;
        env_wr[mem_addr[5:2]]  <= 1'b1;
      end else begin
        mem_rdata <= env_wr[mem_addr[5:2]] ? env_mem[mem_addr[5:2]] : pat(int'(mem_addr[5:2]));
      end
    end
  end

  // Reference model state
  int          own;      // -1 none, else the locking master
  int          beats;
  int          last;
  logic [1:0]  rv_pend;
  logic [31:0] rv_data;
  logic [31:0] exp_mem [16];
  int          last_g;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (rst) return -1;
    if (own >= 0 && req[own]) return own;
    if (req[0] && req[1]) begin
`ifdef DMEM_ARB_RR_EN
      return (last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic drive(input int m, input bit r, input bit w, input bit l,
                       input logic [31:0] a, input logic [31:0] d);
    req[m]   = r;
    we[m]    = w;
    lock[m]  = l;
    addr[m]  = a;
    wdata[m] = d;
  endtask

  // One cycle: check the outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    int          g;
    int          b;
    logic        e_we;
    logic [31:0] e_a, e_d;
    @(negedge clk);
    g    = exp_grant();
    e_we = 1'b0;
    e_a  = '0;
    e_d  = '0;
    if (g >= 0) begin
      e_we = we[g];
      e_a  = addr[g];
      e_d  = wdata[g];
    end
    check("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    check("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    check("mem_en", 32'(mem_en), 32'(g >= 0));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", mem_addr, e_a);
    check("mem_wdata", mem_wdata, e_d);
    check("m0_rvalid", 32'(m0_rvalid), 32'(rv_pend[0] & ~rst));
    check("m1_rvalid", 32'(m1_rvalid), 32'(rv_pend[1] & ~rst));
    if (rv_pend[0] && !rst) check("m0_rdata", m0_rdata, rv_data);
    if (rv_pend[1] && !rst) check("m1_rdata", m1_rdata, rv_data);
    last_g = g;
    @(posedge clk);
    if (rst) begin
      own     = -1;
      beats   = 0;
      last    = 1;
      rv_pend = '0;
    end else begin
      rv_pend = '0;
      if (g >= 0) begin
        if (!we[g]) begin
          rv_pend[g] = 1'b1;
          rv_data    = exp_mem[addr[g][5:2]];
        end else begin
          exp_mem[addr[g][5:2]] = wdata[g];
        end
        last = g;
        b    = (own == g) ? beats + 1 : 1;
        if (lock[g] && b < LockMax) begin
          own   = g;
          beats = b;
        end else begin
          own   = -1;
          beats = 0;
        end
      end else begin
        own   = -1;
        beats = 0;
      end
    end
    #1;
  endtask

  initial begin
    int run;
    bit seen0;
    checks  = 0;
    errors  = 0;
    clk     = 1'b0;
    rst     = 1'b1;
    own     = -1;
    beats   = 0;
    last    = 1;
    rv_pend = '0;
    rv_data = '0;
    last_g  = -1;
    for (int i = 0; i < 16; i++) exp_mem[i] = pat(i);

    // Reset holds every grant and strobe low even with both masters requesting.
    drive(0, 1, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 1, 1, 32'h4, 32'h1234);
    #2;
    check("rst_gnt0_async", 32'(m0_gnt), 32'h0);
    check("rst_mem_en_async", 32'(mem_en), 32'h0);
    step();
    step();
    rst = 1'b0;

    // Both masters read every cycle: alternating grants with RR, otherwise m0 only.
    drive(1, 1, 0, 0, 32'h4, 32'h0);
    for (int i = 0; i < 5; i++) step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();

    // m1 locks for 20 cycles while m0 waits. m0 gets one beat after 16 m1 beats.
    drive(1, 1, 0, 1, 32'h20, 32'h0);
    step();
    run   = (last_g == 1) ? 1 : 0;
    seen0 = 1'b0;
    drive(0, 1, 0, 0, 32'h8, 32'h0);
    for (int i = 1; i < 20; i++) begin
      step();
      if (last_g == 0) begin
        seen0 = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
      end else if (last_g == 1 && !seen0) begin
        run++;
      end
    end
    check("lock_run_len", 32'(run), 32'd16);
    check("m0_after_lock", 32'(seen0), 32'd1);
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();

    // m0 writes 0x10, then m1 reads the same word back.
    drive(0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 0, 0, 32'h10, 32'h0);
    step();
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    #3;
    check("wr_rd_rvalid", 32'(m1_rvalid), 32'd1);
    check("wr_rd_rdata", m1_rdata, 32'hDEADBEEF);
    step();

    // Reset right after a granted read drops the return. Next contention goes to m0.
    drive(0, 1, 0, 0, 32'h4, 32'h0);
    step();
    rst = 1'b1;
    drive(1, 1, 0, 1, 32'hC, 32'h0);
    step();
    rst = 1'b0;
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    step();

    // m0 owns a lock. When m0 drops req, the waiting m1 is granted in the same cycle.
    drive(0, 1, 0, 1, 32'h18, 32'h0);
    step();
    drive(1, 1, 1, 0, 32'h1C, 32'h5555AAAA);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    step();

    // Randomized traffic. Each master holds its request until it is granted.
    for (int i = 0; i < 400; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (!req[m] || last_g == m) begin
          drive(m, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) == 0, {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                $urandom);
        end
      end
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, width of every address port.
REQ-002 SHALL provide parameter DATA_W, default 32, width of every data port.
REQ-003 SHALL provide parameter LOCK_MAX, default 16, maximum number of consecutive locked beats granted to one master.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports m0_req/m1_req  in  1  access request (m0 = core load/store, m1 = debug/loader).
REQ-007 SHALL have ports m0_we/m1_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_lock/m1_lock  in  1  request to keep ownership for the next beat.
REQ-009 SHALL have ports m0_addr/m1_addr  in  ADDR_W  byte address.
REQ-010 SHALL have ports m0_wdata/m1_wdata  in  DATA_W  write data.
REQ-011 SHALL have ports m0_gnt/m1_gnt  out  1  beat accepted this cycle.
REQ-012 SHALL have ports m0_rvalid/m1_rvalid  out  1  read data valid.
REQ-013 SHALL have ports m0_rdata/m1_rdata  out  DATA_W  read data, both driven from mem_rdata.
REQ-014 SHALL have ports mem_en/mem_we  out  1  memory strobe and write enable.
REQ-015 SHALL have ports mem_addr/mem_wdata  out  ADDR_W/DATA_W  address and write data of the granted master.
REQ-016 SHALL have port mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-017 SHALL grant at most one master per cycle; gnt is combinational from req and registered state.
REQ-018 SHALL drive mem_en=gnt0|gnt1, with mem_we/mem_addr/mem_wdata muxed from the granted master in the same cycle; with no grant, mem_en=0 and the other mem_* outputs are 0.
REQ-019 SHALL keep state IDLE/LOCK0/LOCK1 plus last_q (last granted master) and lock_cnt (0..LOCK_MAX).
REQ-020 SHALL grant the owner in LOCKx whenever mx_req=1, regardless of the other request.
REQ-021 SHALL arbitrate in IDLE, or in LOCKx with mx_req=0: a single requester wins; if both request, the winner follows REQ-032.
REQ-022 SHALL enter LOCKx after a grant to x with mx_lock=1 and increment lock_cnt; SHALL return to IDLE and clear lock_cnt after a grant to x with mx_lock=0.
REQ-023 SHALL return to IDLE and clear lock_cnt in any LOCKx cycle with mx_req=0; in that same cycle the other master may be granted.
REQ-024 SHALL ignore mx_lock and return to IDLE, clearing lock_cnt, on the grant that brings lock_cnt to LOCK_MAX.
REQ-025 SHALL update last_q on every grant.
REQ-026 SHALL assert mx_rvalid for exactly one cycle, one cycle after a granted read (we=0) of x; a granted write produces no rvalid.
REQ-027 SHALL let back-to-back reads, from the same or alternating masters, return rvalid on consecutive cycles with no bubble.
REQ-028 SHALL leave requests that are not granted pending; masters hold req/we/addr/wdata/lock until gnt, and the arbiter does not store them.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, last_q=1 (so m0 wins the first contention), lock_cnt=0, and the rvalid pipeline register=0.
REQ-030 SHALL hold gnt0=gnt1=0, mem_en=0, mem_we=0, rvalid=0 and all mem_* buses 0 while rst=1, independent of clk.
REQ-031 SHALL, when rst asserts mid-operation, drop a pending read's rvalid and any lock; the first cycle after release is IDLE arbitration.

Configuration
REQ-032 SHALL compile round-robin contention resolution when DMEM_ARB_RR_EN is defined: the master not equal to last_q wins. Without the macro, m0 always wins contention and last_q is not used for the decision.

Verification
REQ-033 SHALL cover simultaneous reads from both masters each cycle after reset with the macro defined: grants go m0,m1,m0,m1; each rvalid appears one cycle after its gnt with mem_rdata.
REQ-034 SHALL cover the same stimulus without the macro: gnt0 is held high every cycle, gnt1 stays 0, and no rvalid goes to m1.
REQ-035 SHALL cover m1 holding req=1 and lock=1 for 20 cycles while m0 requests: m1 is granted 16 consecutive beats, then m0 is granted one beat, then m1 resumes.
REQ-036 SHALL cover an m0 write to 0x10 of 0xDEADBEEF followed by an m1 read of 0x10: mem_we=1 on the first beat; m1_rvalid=1 two cycles after the write gnt with m1_rdata=0xDEADBEEF from the memory model.
REQ-037 SHALL cover rst pulsed high during the cycle after a granted read: no rvalid is seen, gnt stays 0 during reset, and the first post-reset contention grants m0.
REQ-038 SHALL cover m0 in LOCK0 dropping req: in that same cycle a pending m1 is granted and the state returns to IDLE.
